// File: rtl/hex_ascii_serializer_if.sv
// Handshake bundle for hex_ascii_serializer.
//   in_valid/in_ready/in_data : word capture handshake (producer -> serializer)
//   out_valid/out_ready       : character handshake (serializer -> UART)
//   out_char                  : ASCII character
//   out_last                  : final character of the word
// master = the side wrapped around the serializer (producer + consumer),
// slave  = the serializer itself.
interface hex_ascii_serializer_if #(
  parameter int DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_char;
  logic              out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_char,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_char,
    output out_last
  );
endinterface

// File: rtl/hex_ascii_serializer.sv
// hex_ascii_serializer: captures one DATA_W-bit word and emits its hex
// representation one ASCII character per output handshake, most significant
// nibble first, optionally followed by CR LF.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active-low
//   bus   : hex_ascii_serializer_if.slave (input word / output char handshakes)
//   busy  : high whenever the block is not idle
//
// State table:
//   ST_IDLE | waiting for a word, in_ready high, out_valid low
//   ST_HEX  | presenting hex digit for nibble index cnt_q (cnt_q==0 is the last)
//   ST_CR   | presenting 0x0D
//   ST_LF   | presenting 0x0A, out_last high
module hex_ascii_serializer #(
  parameter int DATA_W      = 128,
  parameter int UPPER       = 0,
  parameter int APPEND_CRLF = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  hex_ascii_serializer_if.slave         bus,
  output logic                          busy
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam bit HAS_CRLF = (APPEND_CRLF != 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEX  = 2'd1;
  localparam logic [1:0] ST_CR   = 2'd2;
  localparam logic [1:0] ST_LF   = 2'd3;

  if ((DATA_W < 4) || ((DATA_W % 4) != 0)) begin : g_bad_width
    $error("hex_ascii_serializer: DATA_W must be a multiple of 4 and at least 4");
  end

  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10)
      c = 8'h30 + {4'h0, nib};
    else if (UPPER != 0)
      c = 8'h37 + {4'h0, nib};   // 10 -> 'A'
    else
      c = 8'h57 + {4'h0, nib};   // 10 -> 'a'
    return c;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] data_shift;
  logic              valid_q, valid_d;
  logic [7:0]        char_q, char_d;
  logic              last_q, last_d;
  logic              in_ready_int;
  logic              accept;

  assign in_ready_int = (state_q == ST_IDLE);
  assign accept       = valid_q && bus.out_ready;

  // The hold register shifts left so the pending digit always comes from the
  // top nibble; this avoids a wide variable-index mux on the nibble counter.
  assign data_shift = data_q << 4;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    char_d  = char_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_int) begin
          data_d  = bus.in_data;
          cnt_d   = CNT_W'(NIB - 1);
          state_d = ST_HEX;
          valid_d = 1'b1;
          char_d  = to_ascii(bus.in_data[DATA_W-1 -: 4]);
          // Only a single-nibble word without terminator is last right away.
          last_d  = !HAS_CRLF && (NIB == 1);
        end
      end

      ST_HEX: begin
        if (accept) begin
          if (cnt_q != '0) begin
            data_d = data_shift;
            cnt_d  = cnt_q - 1'b1;
            char_d = to_ascii(data_shift[DATA_W-1 -: 4]);
            last_d = !HAS_CRLF && (cnt_q == CNT_W'(1));
          end else if (HAS_CRLF) begin
            state_d = ST_CR;
            char_d  = 8'h0D;
            last_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            char_d  = 8'h00;
            last_d  = 1'b0;
          end
        end
      end

      ST_CR: begin
        if (accept) begin
          state_d = ST_LF;
          char_d  = 8'h0A;
          last_d  = 1'b1;
        end
      end

      ST_LF: begin
        if (accept) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          char_d  = 8'h00;
          last_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        char_d  = 8'h00;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      char_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      char_q  <= char_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = valid_q;
  assign bus.out_char  = char_q;
  assign bus.out_last  = last_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hex_ascii_serializer.sv
// Self-checking bench for hex_ascii_serializer: a default 128-bit instance,
// a 16-bit upper-case instance and a 4-bit instance without terminator.
module tb_hex_ascii_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic busy_def, busy_w16, busy_w4;
  int   errors = 0;
  int   checks = 0;

  localparam logic [127:0] W1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ONES = {128{1'b1}};

  hex_ascii_serializer_if #(.DATA_W(128)) if_def ();
  hex_ascii_serializer_if #(.DATA_W(16))  if_w16 ();
  hex_ascii_serializer_if #(.DATA_W(4))   if_w4 ();

  hex_ascii_serializer u_def (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_def.slave),
    .busy  (busy_def)
  );

  hex_ascii_serializer #(.DATA_W(16), .UPPER(1), .APPEND_CRLF(1)) u_w16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_w16.slave),
    .busy  (busy_w16)
  );

  hex_ascii_serializer #(.DATA_W(4), .UPPER(0), .APPEND_CRLF(0)) u_w4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_w4.slave),
    .busy  (busy_w4)
  );

  typedef struct {
    logic [15:0] data;
    logic [47:0] chars;
  } w16_vec_t;

  typedef struct {
    logic [3:0] nib;
    logic [7:0] ch;
  } w4_vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of the default instance character stream (lower case, CR LF).
  function automatic logic [7:0] exp_def(input logic [127:0] word, input int k);
    logic [3:0] n;
    if (k == 32) return 8'h0D;
    if (k == 33) return 8'h0A;
    n = word[127 - 4*k -: 4];
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h61 + {4'h0, n} - 8'd10;
  endfunction

  task automatic start_def(input logic [127:0] word);
    @(negedge clk);
    if_def.in_valid = 1'b1;
    if_def.in_data  = word;
    chk("def_in_ready_idle", 128'(if_def.in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    if_def.in_valid = 1'b0;
    if_def.in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Consume characters of the default instance until stop_at are accepted.
  // strict: out_valid must be high at every sample (full-rate stream).
  // inject_at: once that many characters are accepted, present ONES on in_valid.
  task automatic recv_def(input logic [127:0] word, input int pct, input bit strict,
                          input int stop_at, input int inject_at);
    int         idx = 0;
    int         cyc = 0;
    bit         prev_stall = 1'b0;
    bit         rdy;
    logic [7:0] pc = 8'h00;
    logic       pl = 1'b0;
    while (idx < stop_at && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (if_def.out_valid) begin
        if (prev_stall) begin
          chk("def_hold_char", 128'(if_def.out_char), 128'(pc));
          chk("def_hold_last", 128'(if_def.out_last), 128'(pl));
        end
        chk("def_in_ready_busy", 128'(if_def.in_ready), 128'(1'b0));
        rdy = (pct >= 100) || ($urandom_range(0, 99) < pct);
        if_def.out_ready = rdy;
        if (rdy) begin
          chk($sformatf("def_char%0d", idx), 128'(if_def.out_char), 128'(exp_def(word, idx)));
          chk($sformatf("def_last%0d", idx), 128'(if_def.out_last), 128'(idx == 33));
          idx++;
          if (idx == inject_at) begin
            if_def.in_valid = 1'b1;
            if_def.in_data  = ONES;
          end
        end
        prev_stall = !rdy;
        pc = if_def.out_char;
        pl = if_def.out_last;
      end else begin
        if (strict || prev_stall)
          chk("def_valid_drop", 128'(if_def.out_valid), 128'(1'b1));
        if_def.out_ready = 1'($urandom_range(0, 1));
        prev_stall = 1'b0;
      end
    end
    if (idx < stop_at)
      chk("def_timeout", 128'(idx), 128'(stop_at));
  endtask

  task automatic idle_def(input string name);
    @(negedge clk);
    chk({name, "_valid"},    128'(if_def.out_valid), 128'(1'b0));
    chk({name, "_in_ready"}, 128'(if_def.in_ready),  128'(1'b1));
    chk({name, "_busy"},     128'(busy_def),         128'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w16_vec_t   tv16[5];
    w4_vec_t    tv4[5];
    logic [7:0] c;

    tv16[0] = '{16'hBEEF, 48'h42_45_45_46_0D_0A};
    tv16[1] = '{16'h0000, 48'h30_30_30_30_0D_0A};
    tv16[2] = '{16'h09AF, 48'h30_39_41_46_0D_0A};
    tv16[3] = '{16'h1234, 48'h31_32_33_34_0D_0A};
    tv16[4] = '{16'hC0DE, 48'h43_30_44_45_0D_0A};

    tv4[0] = '{4'hA, 8'h61};
    tv4[1] = '{4'h9, 8'h39};
    tv4[2] = '{4'h0, 8'h30};
    tv4[3] = '{4'hF, 8'h66};
    tv4[4] = '{4'h5, 8'h35};

    rst_n = 1'b0;
    if_def.in_valid = 1'b0; if_def.in_data = '0; if_def.out_ready = 1'b1;
    if_w16.in_valid = 1'b0; if_w16.in_data = '0; if_w16.out_ready = 1'b1;
    if_w4.in_valid  = 1'b0; if_w4.in_data  = '0; if_w4.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_def_valid",    128'(if_def.out_valid), 128'(1'b0));
    chk("rst_def_char",     128'(if_def.out_char),  128'(8'h00));
    chk("rst_def_last",     128'(if_def.out_last),  128'(1'b0));
    chk("rst_def_busy",     128'(busy_def),         128'(1'b0));
    chk("rst_def_in_ready", 128'(if_def.in_ready),  128'(1'b1));
    chk("rst_w16_valid",    128'(if_w16.out_valid), 128'(1'b0));
    chk("rst_w4_in_ready",  128'(if_w4.in_ready),   128'(1'b1));
    rst_n = 1'b1;

    // Full-rate stream of the reference word.
    start_def(W1);
    recv_def(W1, 100, 1'b1, 34, -1);
    idle_def("s1_after");

    // Random back-pressure, about 40% ready.
    start_def(W1);
    recv_def(W1, 40, 1'b0, 34, -1);
    if_def.out_ready = 1'b1;
    idle_def("s2_after");

    // Second word offered mid-stream: captured only once back in IDLE.
    start_def(W1);
    recv_def(W1, 100, 1'b1, 34, 10);
    idle_def("s3_bubble");
    @(posedge clk);
    #1;
    if_def.in_valid = 1'b0;
    recv_def(ONES, 100, 1'b1, 34, -1);
    idle_def("s3_after");

    // Reset while character 5 is pending.
    start_def(W1);
    recv_def(W1, 100, 1'b1, 5, -1);
    @(negedge clk);
    chk("s4_pre_rst_char", 128'(if_def.out_char), 128'(exp_def(W1, 5)));
    rst_n = 1'b0;
    if_def.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("s4_rst_valid",    128'(if_def.out_valid), 128'(1'b0));
    chk("s4_rst_char",     128'(if_def.out_char),  128'(8'h00));
    chk("s4_rst_last",     128'(if_def.out_last),  128'(1'b0));
    chk("s4_rst_busy",     128'(busy_def),         128'(1'b0));
    chk("s4_rst_in_ready", 128'(if_def.in_ready),  128'(1'b1));
    if_def.out_ready = 1'b1;
    start_def(128'h1);
    recv_def(128'h1, 100, 1'b1, 34, -1);
    idle_def("s4_after");

    // 16-bit upper-case instance, table-driven.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_w16.in_valid = 1'b1;
      if_w16.in_data  = tv16[i].data;
      @(posedge clk);
      #1;
      if_w16.in_valid = 1'b0;
      if_w16.in_data  = 16'h5A5A;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        c = tv16[i].chars[47 - 8*k -: 8];
        chk($sformatf("w16_v%0d_valid%0d", i, k), 128'(if_w16.out_valid), 128'(1'b1));
        chk($sformatf("w16_v%0d_char%0d", i, k),  128'(if_w16.out_char),  128'(c));
        chk($sformatf("w16_v%0d_last%0d", i, k),  128'(if_w16.out_last),  128'(k == 5));
      end
      @(negedge clk);
      chk($sformatf("w16_v%0d_idle", i),     128'(if_w16.out_valid), 128'(1'b0));
      chk($sformatf("w16_v%0d_in_ready", i), 128'(if_w16.in_ready),  128'(1'b1));
    end

    // 4-bit instance, back-to-back words with in_valid held high.
    @(negedge clk);
    if_w4.in_valid = 1'b1;
    if_w4.in_data  = tv4[0].nib;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) if_w4.in_valid = 1'b0;
      else        if_w4.in_data  = tv4[i+1].nib;
      @(negedge clk);
      chk($sformatf("w4_v%0d_valid", i),    128'(if_w4.out_valid), 128'(1'b1));
      chk($sformatf("w4_v%0d_char", i),     128'(if_w4.out_char),  128'(tv4[i].ch));
      chk($sformatf("w4_v%0d_last", i),     128'(if_w4.out_last),  128'(1'b1));
      chk($sformatf("w4_v%0d_in_ready", i), 128'(if_w4.in_ready),  128'(1'b0));
      @(negedge clk);
      chk($sformatf("w4_v%0d_bubble", i),   128'(if_w4.out_valid), 128'(1'b0));
      chk($sformatf("w4_v%0d_ready", i),    128'(if_w4.in_ready),  128'(1'b1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_ascii_serializer.md
Name: hex_ascii_serializer

Overview:
- Parametrised successor to the team's 4-bit binary-to-ASCII converter.
- Accepts one DATA_W-bit word, such as an AES state or ciphertext block, over a valid/ready handshake.
- Emits the word's hex representation one ASCII character per output handshake, most significant nibble first, with optional CR/LF line terminator.
- Sits between the AES core and the UART transmitter for printing results.

Parameters:
- DATA_W, 128, input word width; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- UPPER, 0, 0 = digits a-f as 0x61-0x66; 1 = A-F as 0x41-0x46.
- APPEND_CRLF, 1, 1 = append 0x0D then 0x0A after the last hex digit; 0 = no terminator.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can capture a word; high only in IDLE.
- in_data  input  DATA_W  word to print.
- out_valid  output  1  out_char is valid.
- out_ready  input  1  downstream (UART) accepts out_char.
- out_char  output  8  ASCII character.
- out_last  output  1  high with the final character of the word.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE; nibble counter cleared.
  - out_valid=0, out_char=8'h00, out_last=0, busy=0, in_ready=1.
  - Reset overrides every other input, including mid-stream; any partially sent word is discarded.
- NIB = DATA_W/4. Nibble counter width is clog2(NIB), minimum 1.
- Characters per word = NIB + 2*APPEND_CRLF.
- States: IDLE, HEX, CR, LF.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: register in_data into a shift/hold register, set counter=NIB-1, go to HEX.
  - At the same edge: out_valid<=1, out_char<=ASCII(in_data[DATA_W-1 -: 4]).
  - Latency: first character is valid in the cycle immediately after capture.
- HEX:
  - out_char = ASCII of nibble[counter], using the mapping 0-9 -> 0x30-0x39 and 10-15 -> per UPPER.
  - On out_valid && out_ready with counter>0: decrement counter and load the next lower nibble's character.
  - On accept with counter==0: go to CR if APPEND_CRLF, otherwise to IDLE with out_valid<=0.
- CR: out_char=0x0D. On accept, go to LF.
- LF: out_char=0x0A, out_last=1. On accept, go to IDLE with out_valid<=0.
- out_last placement: with APPEND_CRLF=0, out_last=1 during the final hex character (counter==0) only. It is never high otherwise.
- Handshake rules:
  - While out_valid && !out_ready, out_char and out_last hold stable.
  - out_valid never drops without an accept, except at reset.
  - out_valid, out_char and out_last are registered outputs.
- Input rules:
  - in_valid outside IDLE is ignored; the word is not captured and in_ready=0.
  - in_data may change freely after capture.
- Back-to-back: the edge accepting the last character returns to IDLE. A new word can be captured on the next edge, giving a one-cycle out_valid bubble between words.
- Simultaneous events: capture and output accept cannot coincide, because out_valid=0 in IDLE.
- Ready independence: out_ready high while out_valid=0 has no effect. No combinational path from out_ready to out_valid or out_char.
- Single-nibble case: DATA_W=4 works with NIB=1 and counter fixed at 0.

Test Plan:
- Default params, in_data=128'h00112233445566778899aabbccddeeff, out_ready=1:
  - 34 consecutive characters "00112233445566778899aabbccddeeff", then 0x0D, 0x0A.
  - out_last only on 0x0A; in_ready=0 throughout, 1 the cycle after.
- DATA_W=16, UPPER=1, in_data=16'hBEEF -> 0x42 0x45 0x45 0x46 0x0D 0x0A, one per cycle, out_last on 0x0A.
- Default params, random out_ready (~40% duty):
  - out_char/out_last stable whenever out_valid && !out_ready.
  - Character sequence identical to the first scenario; no drops or duplicates.
- Second word 128'hffff...ff presented on in_valid during character 10 of the first word:
  - Not captured mid-stream; captured on the first edge in IDLE.
  - Followed by 32x 0x66, 0x0D, 0x0A.
- Reset mid-stream: rst_n=0 for one edge while character 5 is pending:
  - Next cycle out_valid=0, out_char=0x00, busy=0, in_ready=1.
  - A new word 128'h1 then prints 31x 0x30, then 0x31, 0x0D, 0x0A.
- DATA_W=4, APPEND_CRLF=0, in_data=4'hA:
  - Single character 0x61 with out_last=1.
  - Back-to-back 4'h9 yields 0x39 after one idle cycle.
